// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Tracks register writes that are still in flight in the stages after ID
// (entry 0 = EXE ... entry NUM_STAGES-1 = WB) as a shift register of
// {valid, dest, is_load} entries. Each cycle it resolves every ID source
// operand against the scoreboard. For each source it either forwards the
// result held in the matching stage, or raises a load-use stall when the
// youngest producer is a load whose data is not yet available.
//
// Ports:
//   clk, rst_b       clock and synchronous active-low reset
//   issue_*          instruction leaving ID this cycle (dest, writes, is load)
//   flush            turn the issuing instruction into a bubble
//   freeze           MEM freeze; scoreboard and stall counter hold
//   src_num/valid    packed source register numbers and read enables
//   stage_data       packed result currently held in each tracked stage
//   src_fwd_en/data  per-source forwarding select and forwarded value
//   stall            load-use hazard; ID holds and a bubble enters EXE
//   occupancy        number of valid writing entries
//   stall_cycles     saturating count of non-frozen stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_STAGES       = 3,
    parameter int NUM_SRC          = 3,
    parameter int REG_ADDR_W       = 5,
    parameter int DATA_W           = 32,
    parameter int LOAD_READY_STAGE = 2,
    parameter int CNT_W            = 32
) (
    input  logic                               clk,
    input  logic                               rst_b,
    input  logic                               issue_valid,
    input  logic [REG_ADDR_W-1:0]              issue_dest,
    input  logic                               issue_reg_write,
    input  logic                               issue_is_load,
    input  logic                               flush,
    input  logic                               freeze,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]      src_num,
    input  logic [NUM_SRC-1:0]                 src_valid,
    input  logic [NUM_STAGES*DATA_W-1:0]       stage_data,
    output logic [NUM_SRC-1:0]                 src_fwd_en,
    output logic [NUM_SRC*DATA_W-1:0]          src_fwd_data,
    output logic                               stall,
    output logic [$clog2(NUM_STAGES+1)-1:0]    occupancy,
    output logic [CNT_W-1:0]                   stall_cycles
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] entry_valid;
    logic [NUM_STAGES-1:0] entry_is_load;
    logic [REG_ADDR_W-1:0] entry_dest [NUM_STAGES];

    logic [NUM_SRC-1:0]    load_use;
    logic                  new_valid;

    // Register 0 is hardwired to zero, so writes to it never create an entry.
    // A stall or a flush turns the issuing slot into a bubble.
    assign new_valid = issue_valid && !stall && !flush &&
                       issue_reg_write && (issue_dest != '0);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            entry_valid   <= '0;
            entry_is_load <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                entry_dest[i] <= '0;
            end
            stall_cycles  <= '0;
        end else if (!freeze) begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                entry_valid[i]   <= entry_valid[i-1];
                entry_is_load[i] <= entry_is_load[i-1];
                entry_dest[i]    <= entry_dest[i-1];
            end
            entry_valid[0]   <= new_valid;
            entry_is_load[0] <= new_valid && issue_is_load;
            entry_dest[0]    <= issue_dest;
            if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [REG_ADDR_W-1:0] num;
        logic                  hit;
        logic                  blocked;
        logic                  active;
        logic [DATA_W-1:0]     data;

        assign num = src_num[k*REG_ADDR_W +: REG_ADDR_W];

        // Scan from oldest to youngest so the youngest match overwrites any
        // older one. A load is blocked until it reaches LOAD_READY_STAGE.
        always_comb begin
            hit     = 1'b0;
            blocked = 1'b0;
            data    = '0;
            for (int i = NUM_STAGES - 1; i >= 0; i--) begin
                if (entry_valid[i] && (entry_dest[i] == num)) begin
                    hit     = 1'b1;
                    blocked = entry_is_load[i] && (i < LOAD_READY_STAGE);
                    data    = stage_data[i*DATA_W +: DATA_W];
                end
            end
        end

        assign active        = src_valid[k] && (num != '0) && hit;
        assign load_use[k]   = active && blocked;
        assign src_fwd_en[k] = active && !blocked;
        assign src_fwd_data[k*DATA_W +: DATA_W] = src_fwd_en[k] ? data : '0;
    end

    // Stall is also asserted while frozen. The frozen pipeline ignores it,
    // and the counter does not advance.
    assign stall = |load_use;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            occupancy = occupancy + OCC_W'(entry_valid[i]);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard with default parameters. Each step
// drives inputs after the falling edge and queues the values the outputs
// must show. Once the combinational outputs settle, it pops the queue and
// compares each value, then lets the rising edge commit the cycle.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NS  = 3;
    localparam int NSR = 3;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int CW  = 32;
    localparam int OW  = $clog2(NS + 1);

    localparam int K_EN    = 0;
    localparam int K_DATA  = 1;
    localparam int K_STALL = 2;
    localparam int K_OCC   = 3;
    localparam int K_CNT   = 4;

    typedef struct {
        string       tag;
        int          kind;
        int          k;
        logic [31:0] value;
    } exp_t;

    logic                 clk;
    logic                 rst_b;
    logic                 issue_valid;
    logic [AW-1:0]        issue_dest;
    logic                 issue_reg_write;
    logic                 issue_is_load;
    logic                 flush;
    logic                 freeze;
    logic [NSR*AW-1:0]    src_num;
    logic [NSR-1:0]       src_valid;
    logic [NS*DW-1:0]     stage_data;
    logic [NSR-1:0]       src_fwd_en;
    logic [NSR*DW-1:0]    src_fwd_data;
    logic                 stall;
    logic [OW-1:0]        occupancy;
    logic [CW-1:0]        stall_cycles;

    exp_t exp_q[$];
    int   pass_count  = 0;
    int   total_count = 0;

    hazard_scoreboard dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .issue_valid     (issue_valid),
        .issue_dest      (issue_dest),
        .issue_reg_write (issue_reg_write),
        .issue_is_load   (issue_is_load),
        .flush           (flush),
        .freeze          (freeze),
        .src_num         (src_num),
        .src_valid       (src_valid),
        .stage_data      (stage_data),
        .src_fwd_en      (src_fwd_en),
        .src_fwd_data    (src_fwd_data),
        .stall           (stall),
        .occupancy       (occupancy),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic iv, input logic [AW-1:0] dest,
                                 input logic rw, input logic ld,
                                 input logic fl, input logic fz);
        issue_valid     = iv;
        issue_dest      = dest;
        issue_reg_write = rw;
        issue_is_load   = ld;
        flush           = fl;
        freeze          = fz;
    endtask

    task automatic setSrc(input int k, input logic [AW-1:0] num, input logic v);
        src_num[k*AW +: AW] = num;
        src_valid[k]        = v;
    endtask

    task automatic clearSrc();
        src_num   = '0;
        src_valid = '0;
    endtask

    task automatic setData(input int i, input logic [DW-1:0] v);
        stage_data[i*DW +: DW] = v;
    endtask

    task automatic expectVal(input string tag, input int kind, input int k,
                             input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.kind  = kind;
        e.k     = k;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Compare everything queued for this cycle, then advance one clock.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_EN:    obs = 32'(src_fwd_en[e.k]);
                K_DATA:  obs = src_fwd_data[e.k*DW +: DW];
                K_STALL: obs = 32'(stall);
                K_OCC:   obs = 32'(occupancy);
                default: obs = stall_cycles;
            endcase
            total_count++;
            assert (obs === e.value) begin
                pass_count++;
            end else begin
                $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", e.tag, obs, e.value);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput();
        end
    endtask

    initial begin
        rst_b = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        clearSrc();
        stage_data = '0;
        @(negedge clk);

        // Reset edge
        checkOutput();
        rst_b = 1'b1;
        setSrc(0, 5'd3, 1'b1);
        expectVal("rst_occ",   K_OCC,   0, 32'd0);
        expectVal("rst_stall", K_STALL, 0, 32'd0);
        expectVal("rst_cnt",   K_CNT,   0, 32'd0);
        expectVal("rst_en0",   K_EN,    0, 32'd0);
        expectVal("rst_data0", K_DATA,  0, 32'd0);
        checkOutput();
        clearSrc();

        // ALU back-to-back forwarding from EXE
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        setSrc(0, 5'd3, 1'b1);
        setData(0, 32'h11);
        expectVal("alu_en0",   K_EN,    0, 32'd1);
        expectVal("alu_data0", K_DATA,  0, 32'h11);
        expectVal("alu_stall", K_STALL, 0, 32'd0);
        expectVal("alu_occ",   K_OCC,   0, 32'd1);
        checkOutput();
        clearSrc();
        idleCycles(3);

        // Load-use: two stall cycles, then forward from stage 2
        setData(0, 32'h100);
        setData(1, 32'h200);
        setData(2, 32'hAB);
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        expectVal("ld_occ0", K_OCC, 0, 32'd0);
        checkOutput();
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        setSrc(1, 5'd5, 1'b1);
        expectVal("ld_stall1", K_STALL, 0, 32'd1);
        expectVal("ld_en1_c1", K_EN,    1, 32'd0);
        expectVal("ld_cnt_c1", K_CNT,   0, 32'd0);
        checkOutput();
        expectVal("ld_stall2", K_STALL, 0, 32'd1);
        expectVal("ld_en1_c2", K_EN,    1, 32'd0);
        expectVal("ld_occ_c2", K_OCC,   0, 32'd1);
        expectVal("ld_cnt_c2", K_CNT,   0, 32'd1);
        checkOutput();
        expectVal("ld_stall3", K_STALL, 0, 32'd0);
        expectVal("ld_en1_c3", K_EN,    1, 32'd1);
        expectVal("ld_data1",  K_DATA,  1, 32'hAB);
        expectVal("ld_cnt_c3", K_CNT,   0, 32'd2);
        checkOutput();
        clearSrc();
        setSrc(0, 5'd9, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectVal("ld_consumer_en",   K_EN,   0, 32'd1);
        expectVal("ld_consumer_data", K_DATA, 0, 32'h100);
        checkOutput();
        clearSrc();
        idleCycles(3);

        // Youngest match wins over an older write of the same register
        applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        setData(0, 32'h1);
        setData(2, 32'h2);
        setSrc(0, 5'd7, 1'b1);
        setSrc(2, 5'd7, 1'b0);
        expectVal("young_en0",   K_EN,   0, 32'd1);
        expectVal("young_data0", K_DATA, 0, 32'h1);
        expectVal("young_occ",   K_OCC,  0, 32'd2);
        expectVal("young_en2",   K_EN,   2, 32'd0);
        expectVal("young_data2", K_DATA, 2, 32'h0);
        checkOutput();
        clearSrc();
        idleCycles(3);

        // Freeze holds the load in EXE and the stall counter
        setData(2, 32'hCD);
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput();
        setSrc(1, 5'd5, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
            expectVal("frz_stall", K_STALL, 0, 32'd1);
            expectVal("frz_occ",   K_OCC,   0, 32'd1);
            expectVal("frz_cnt",   K_CNT,   0, 32'd2);
            checkOutput();
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expectVal("thaw_stall1", K_STALL, 0, 32'd1);
        expectVal("thaw_cnt1",   K_CNT,   0, 32'd2);
        checkOutput();
        expectVal("thaw_stall2", K_STALL, 0, 32'd1);
        expectVal("thaw_cnt2",   K_CNT,   0, 32'd3);
        checkOutput();
        expectVal("thaw_stall3", K_STALL, 0, 32'd0);
        expectVal("thaw_en1",    K_EN,    1, 32'd1);
        expectVal("thaw_data1",  K_DATA,  1, 32'hCD);
        expectVal("thaw_cnt3",   K_CNT,   0, 32'd4);
        checkOutput();
        clearSrc();
        idleCycles(3);

        // Register zero never tracked; flushed issue never tracked
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        setData(0, 32'h55);
        setSrc(0, 5'd0, 1'b1);
        expectVal("r0_occ",   K_OCC,  0, 32'd0);
        expectVal("r0_en0",   K_EN,   0, 32'd0);
        expectVal("r0_data0", K_DATA, 0, 32'h0);
        checkOutput();
        clearSrc();
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        setSrc(0, 5'd4, 1'b1);
        expectVal("flush_en0", K_EN,  0, 32'd0);
        expectVal("flush_occ", K_OCC, 0, 32'd0);
        checkOutput();
        clearSrc();

        // Mid-run reset with three entries and a pending stall
        applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        setSrc(0, 5'd6, 1'b1);
        setSrc(1, 5'd8, 1'b1);
        rst_b = 1'b0;
        expectVal("pre_rst_occ",   K_OCC,   0, 32'd3);
        expectVal("pre_rst_stall", K_STALL, 0, 32'd1);
        expectVal("pre_rst_en1",   K_EN,    1, 32'd1);
        checkOutput();
        rst_b = 1'b1;
        expectVal("mid_rst_occ",   K_OCC,   0, 32'd0);
        expectVal("mid_rst_stall", K_STALL, 0, 32'd0);
        expectVal("mid_rst_cnt",   K_CNT,   0, 32'd0);
        expectVal("mid_rst_en0",   K_EN,    0, 32'd0);
        expectVal("mid_rst_en1",   K_EN,    1, 32'd0);
        checkOutput();

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
